stream_xor_encryptor: RTL and testbench

Byte-wide encrypt/decrypt stage that sits directly downstream of the XTEA keystream hash generator. It accepts one plaintext byte at a time over a valid/ready handshake and issues a single-cycle keystream request to the generator. It waits for the generator's byte pulse, XORs the keystream byte into the data byte, and presents the result on a valid/ready output. It also counts processed bytes, owns the stream restart, and flags a stalled keystream with a sticky timeout error.

---
 rtl/stream_xor_encryptor.sv | 114 +++++++++++
 tb/tb_stream_xor_encryptor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_xor_encryptor.sv
// Byte XOR stage: latches one input byte, requests one keystream byte, emits byte ^ keystream.
// Latency: accept edge N, result valid at edge N+2+keystream delay; output held until data_out_ready, no new byte accepted meanwhile.
module stream_xor_encryptor #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   reset_stream,
    input  logic [7:0]             data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic [7:0]             hash_byte_in,
    input  logic                   hash_byte_pulse_in,
    output logic                   request_hash_byte_pulse_out,
    output logic                   reset_hash_out,
    output logic [7:0]             data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic [COUNT_WIDTH-1:0] byte_count_out,
    output logic                   timeout_error_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_HASH,
        OUTPUT,
        ERROR
    } state_t;

    typedef struct packed {
        state_t                 state;
        logic [7:0]             latched;
        logic [7:0]             dout;
        logic                   dout_vld;
        logic                   req;
        logic [COUNT_WIDTH-1:0] count;
        logic                   err;
        logic [TW-1:0]          timer;
    } regs_t;

    regs_t r;
    regs_t r_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r <= '0;
        end else begin
            r <= r_nxt;
        end
    end

    always_comb begin
        r_nxt     = r;
        r_nxt.req = 1'b0;
        if (reset_stream) begin
            // stream restart wins over every other event, including a pending handshake
            r_nxt       = '0;
            r_nxt.state = IDLE;
        end else begin
            case (r.state)
                IDLE: begin
                    if (data_in_valid) begin
                        r_nxt.latched = data_in;
                        r_nxt.req     = 1'b1;
                        r_nxt.state   = REQUEST;
                    end
                end
                REQUEST: begin
                    r_nxt.timer = '0;
                    r_nxt.state = WAIT_HASH;
                end
                WAIT_HASH: begin
                    if (hash_byte_pulse_in) begin
                        r_nxt.dout     = r.latched ^ hash_byte_in;
                        r_nxt.dout_vld = 1'b1;
                        r_nxt.state    = OUTPUT;
                    end else if (r.timer == TIMER_LAST) begin
                        r_nxt.err   = 1'b1;
                        r_nxt.state = ERROR;
                    end else begin
                        r_nxt.timer = r.timer + TW'(1);
                    end
                end
                OUTPUT: begin
                    if (data_out_ready) begin
                        r_nxt.dout_vld = 1'b0;
                        r_nxt.count    = r.count + COUNT_WIDTH'(1);
                        r_nxt.state    = IDLE;
                    end
                end
                ERROR: begin
                    r_nxt.state = ERROR;
                end
                default: begin
                    r_nxt.state = IDLE;
                end
            endcase
        end
    end

    assign data_in_ready               = (r.state == IDLE) && !reset_stream;
    assign reset_hash_out              = reset_stream;
    assign request_hash_byte_pulse_out = r.req;
    assign data_out                    = r.dout;
    assign data_out_valid              = r.dout_vld;
    assign byte_count_out              = r.count;
    assign timeout_error_out           = r.err;

endmodule

// File: tb/tb_stream_xor_encryptor.sv
// Bench for stream_xor_encryptor: directed scenarios with literal expectations, then random traffic
// against a timeline model of each in-flight byte.
module tb_stream_xor_encryptor;

    localparam int TMO = 8;
    localparam int CW  = 2;
    localparam int CNT_MOD = 1 << CW;

    logic          clk;
    logic          nrst;
    logic          reset_stream;
    logic [7:0]    data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [7:0]    hash_byte_in;
    logic          hash_byte_pulse_in;
    logic          request_hash_byte_pulse_out;
    logic          reset_hash_out;
    logic [7:0]    data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [CW-1:0] byte_count_out;
    logic          timeout_error_out;

    int total = 0;
    int bad   = 0;
    int nreq  = 0;

    stream_xor_encryptor #(.TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(CW)) dut (
        .clk                         (clk),
        .nrst                        (nrst),
        .reset_stream                (reset_stream),
        .data_in                     (data_in),
        .data_in_valid               (data_in_valid),
        .data_in_ready               (data_in_ready),
        .hash_byte_in                (hash_byte_in),
        .hash_byte_pulse_in          (hash_byte_pulse_in),
        .request_hash_byte_pulse_out (request_hash_byte_pulse_out),
        .reset_hash_out              (reset_hash_out),
        .data_out                    (data_out),
        .data_out_valid              (data_out_valid),
        .data_out_ready              (data_out_ready),
        .byte_count_out              (byte_count_out),
        .timeout_error_out           (timeout_error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: life of one byte measured in cycles since acceptance.
    // age 0 = request cycle; age k>=1 = keystream wait slot k-1; timeout after slot TMO-1.
    logic       m_busy, m_got, m_err, m_vld, m_req;
    logic [7:0] m_byte, m_out;
    int         m_age, m_cnt;

    always @(posedge clk or negedge nrst) begin
        if (!nrst || reset_stream) begin
            m_busy <= 1'b0; m_got <= 1'b0; m_err <= 1'b0; m_vld <= 1'b0; m_req <= 1'b0;
            m_byte <= 8'h00; m_out <= 8'h00; m_age <= 0; m_cnt <= 0;
        end else begin
            m_req <= 1'b0;
            if (m_err) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (data_in_valid) begin
                    m_busy <= 1'b1; m_got <= 1'b0; m_age <= 0;
                    m_byte <= data_in; m_req <= 1'b1;
                end
            end else if (m_got) begin
                if (data_out_ready) begin
                    m_vld  <= 1'b0;
                    m_cnt  <= (m_cnt + 1) % CNT_MOD;
                    m_busy <= 1'b0;
                end
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (hash_byte_pulse_in) begin
                m_out <= m_byte ^ hash_byte_in;
                m_vld <= 1'b1;
                m_got <= 1'b1;
            end else if (m_age - 1 == TMO - 1) begin
                m_err  <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (request_hash_byte_pulse_out) nreq++;
        chk("in_ready",  32'(data_in_ready),               32'(!m_busy && !m_err && !reset_stream));
        chk("reset_hash", 32'(reset_hash_out),             32'(reset_stream));
        chk("request",   32'(request_hash_byte_pulse_out), 32'(m_req));
        chk("out_valid", 32'(data_out_valid),              32'(m_vld));
        chk("data_out",  32'(data_out),                    32'(m_out));
        chk("count",     32'(byte_count_out),              32'(m_cnt));
        chk("error",     32'(timeout_error_out),           32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one byte; stub answers with h after 'dly' wait slots; consumer stalls 'bp' cycles.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] h, input int dly,
                             input int bp, output logic [7:0] got);
        int n = 0;
        while (!data_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("wait_ready_timeout", 32'(n), 32'(0));
        data_in = d; data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        step();
        repeat (dly) step();
        hash_byte_in = h; hash_byte_pulse_in = 1'b1;
        step();
        hash_byte_pulse_in = 1'b0;
        chk("valid_after_pulse", 32'(data_out_valid), 32'(1));
        repeat (bp) begin
            step();
            chk("held_valid", 32'(data_out_valid), 32'(1));
        end
        data_out_ready = 1'b1;
        got = data_out;
        step();
        data_out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp_stream [3];
        nrst = 1'b0; reset_stream = 1'b0; data_in = 8'h00; data_in_valid = 1'b0;
        hash_byte_in = 8'h00; hash_byte_pulse_in = 1'b0; data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        #1;
        chk("rst_ready", 32'(data_in_ready), 32'(1));
        chk("rst_count", 32'(byte_count_out), 32'(0));
        chk("rst_dout",  32'(data_out), 32'(0));
        chk("rst_err",   32'(timeout_error_out), 32'(0));
        chk("rst_rhash", 32'(reset_hash_out), 32'(0));
        step();

        send_byte(8'h5A, 8'hFF, 1, 0, got);
        chk("single_data", 32'(got), 32'hA5);
        chk("single_count", 32'(byte_count_out), 32'(1));
        chk("single_nreq", 32'(nreq), 32'(1));

        send_byte(8'h5A, 8'hFF, 0, 5, got);
        chk("bp_data", 32'(got), 32'hA5);
        chk("bp_count", 32'(byte_count_out), 32'(2));
        chk("bp_nreq", 32'(nreq), 32'(2));

        reset_stream = 1'b1;
        step();
        reset_stream = 1'b0;
        hash_byte_in = 8'h77; hash_byte_pulse_in = 1'b1;
        step();
        hash_byte_pulse_in = 1'b0;
        chk("stray_dout", 32'(data_out), 32'(0));
        chk("stray_count", 32'(byte_count_out), 32'(0));
        exp_stream[0] = 8'h10; exp_stream[1] = 8'h21; exp_stream[2] = 8'h32;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(i), 8'((i + 1) * 16), i, 1, got);
            chk("stream_data", 32'(got), 32'(exp_stream[i]));
        end
        chk("stream_count", 32'(byte_count_out), 32'(3));

        data_in = 8'h33; data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        step();
        repeat (7) step();
        chk("tmo_early", 32'(timeout_error_out), 32'(0));
        step();
        chk("tmo_err", 32'(timeout_error_out), 32'(1));
        chk("tmo_ready", 32'(data_in_ready), 32'(0));
        reset_stream = 1'b1;
        #1;
        chk("tmo_rhash", 32'(reset_hash_out), 32'(1));
        chk("tmo_rs_ready", 32'(data_in_ready), 32'(0));
        step();
        reset_stream = 1'b0;
        #1;
        chk("tmo_cleared", 32'(timeout_error_out), 32'(0));
        chk("tmo_ready_back", 32'(data_in_ready), 32'(1));

        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC0, 8'(i), 2, 0, got);
            chk("wrap_data", 32'(got), 32'(8'hC0 ^ 8'(i)));
            chk("wrap_count", 32'(byte_count_out), 32'((i + 1) % 4));
        end
        send_byte(8'h0F, 8'hF0, TMO - 1, 0, got);
        chk("prio_data", 32'(got), 32'hFF);
        chk("prio_err", 32'(timeout_error_out), 32'(0));

        for (int c = 0; c < 4000; c++) begin
            nrst           = ($urandom_range(0, 399) != 0);
            reset_stream   = ($urandom_range(0, 59) == 0);
            data_in_valid  = ($urandom_range(0, 1) == 1);
            data_in        = 8'($urandom);
            hash_byte_in   = 8'($urandom);
            hash_byte_pulse_in = ($urandom_range(0, 3) == 0);
            data_out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        nrst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
